// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for a 4-bit x^4+x^3+1 Fibonacci LFSR stream.
// Hunts for a legal seed, verifies LOCK_CNT follow-on samples, then flywheels and counts mismatches.
module lfsr_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [3:0]       rx_data,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_o
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  logic [1:0]       state, state_nxt;
  logic [3:0]       exp, exp_nxt;
  logic [3:0]       good_cnt, good_nxt;
  logic [3:0]       bad_cnt, bad_nxt;
  logic             miss;
  logic             match;
  logic [ERR_W-1:0] err_base, err_nxt;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk_n) begin
    if (rst) begin
      state     <= HUNT;
      exp       <= 4'b0001;
      good_cnt  <= 4'd0;
      bad_cnt   <= 4'd0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      exp       <= exp_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      err_pulse <= miss;
      err_cnt   <= err_nxt;
    end
  end

  // Next-state logic; idle cycles fall through with everything held
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    miss      = 1'b0;
    match     = (rx_data == exp);
    if (rx_valid) begin
      case (state)
        HUNT: begin
          if (rx_data != 4'd0) begin
            exp_nxt   = lfsr_next(rx_data);
            good_nxt  = 4'd0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_nxt  = lfsr_next(exp);
            good_nxt = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_TGT) begin
              state_nxt = LOCKED;
              bad_nxt   = 4'd0;
            end
          end else if (rx_data != 4'd0) begin
            exp_nxt  = lfsr_next(rx_data);
            good_nxt = 4'd0;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: never re-seed from the wire once locked
          exp_nxt = lfsr_next(exp);
          if (match) begin
            bad_nxt = 4'd0;
          end else begin
            miss = 1'b1;
            if (bad_cnt + 4'd1 == LOSS_TGT) begin
              state_nxt = HUNT;
              good_nxt  = 4'd0;
              bad_nxt   = 4'd0;
            end else begin
              bad_nxt = bad_cnt + 4'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    // Clear lands before the increment so a simultaneous miss leaves a count of one
    err_base = err_clr ? '0 : err_cnt;
    err_nxt  = miss ? sat_inc(err_base) : err_base;
  end

  // Outputs
  always_comb begin
    locked  = (state == LOCKED);
    state_o = state;
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Randomised and directed bench for lfsr_seq_checker against a table-driven reference model.
// Two instances (ERR_W=8 and ERR_W=2) share stimulus so counter saturation is exercised.
module tb_lfsr_seq_checker;

  logic       clk_n = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [3:0] rx_data = 4'd0;
  logic       err_clr = 1'b0;

  logic       locked_a, pulse_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;
  logic       locked_b, pulse_b;
  logic [1:0] cnt_b;
  logic [1:0] st_b;

  int checks = 0;
  int failures = 0;

  int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  int         m_state;
  logic [3:0] m_exp;
  int         m_good, m_bad;
  int         m_pulse;
  int         m_err8, m_err2;

  always #5 clk_n = ~clk_n;

  lfsr_seq_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut_a (
    .clk_n(clk_n), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .err_clr(err_clr),
    .locked(locked_a), .err_pulse(pulse_a), .err_cnt(cnt_a), .state_o(st_a)
  );

  lfsr_seq_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(2)) dut_b (
    .clk_n(clk_n), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .err_clr(err_clr),
    .locked(locked_b), .err_pulse(pulse_b), .err_cnt(cnt_b), .state_o(st_b)
  );

  function automatic logic [3:0] ref_next(input logic [3:0] x);
    for (int i = 0; i < 15; i++)
      if (seq[i] == int'(x)) return 4'(seq[(i + 1) % 15]);
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic model_edge();
    int mis;
    mis = 0;
    if (rst) begin
      m_state = 0; m_exp = 4'd1; m_good = 0; m_bad = 0;
      m_pulse = 0; m_err8 = 0; m_err2 = 0;
      return;
    end
    if (rx_valid) begin
      if (m_state == 0) begin
        if (rx_data != 4'd0) begin
          m_exp = ref_next(rx_data); m_good = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (rx_data == m_exp) begin
          m_exp = ref_next(m_exp); m_good++;
          if (m_good == 3) begin m_state = 2; m_bad = 0; end
        end else if (rx_data != 4'd0) begin
          m_exp = ref_next(rx_data); m_good = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        mis = (rx_data != m_exp) ? 1 : 0;
        m_exp = ref_next(m_exp);
        if (mis == 0) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == 2) begin m_state = 0; m_good = 0; end
        end
      end
    end
    m_pulse = mis;
    if (err_clr) begin m_err8 = 0; m_err2 = 0; end
    if (mis != 0) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c, input string tag);
    @(negedge clk_n);
    rst = r; rx_valid = v; rx_data = d; err_clr = c;
    @(posedge clk_n);
    model_edge();
    #1;
    chk({tag, ".state_a"}, int'(st_a), m_state);
    chk({tag, ".state_b"}, int'(st_b), m_state);
    chk({tag, ".locked_a"}, int'(locked_a), (m_state == 2) ? 1 : 0);
    chk({tag, ".locked_b"}, int'(locked_b), (m_state == 2) ? 1 : 0);
    chk({tag, ".pulse_a"}, int'(pulse_a), m_pulse);
    chk({tag, ".pulse_b"}, int'(pulse_b), m_pulse);
    chk({tag, ".cnt8"}, int'(cnt_a), m_err8);
    chk({tag, ".cnt2"}, int'(cnt_b), m_err2);
  endtask

  initial begin
    logic [3:0] lock_seq [4];
    int pos;
    int r;
    lock_seq = '{4'b1011, 4'b0111, 4'b1111, 4'b1110};
    m_state = 0; m_exp = 4'd1; m_good = 0; m_bad = 0; m_pulse = 0; m_err8 = 0; m_err2 = 0;

    // Reset wins even with a valid sample present
    step(1'b1, 1'b1, 4'b0011, 1'b0, "rst");
    chk("rst_state", int'(st_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);

    // 1. Lock
    step(1'b0, 1'b1, lock_seq[0], 1'b0, "t1");
    chk("t1_verify", int'(st_a), 1);
    for (int i = 1; i < 4; i++) step(1'b0, 1'b1, lock_seq[i], 1'b0, "t1");
    chk("t1_locked", int'(locked_a), 1);
    chk("t1_nocnt", int'(cnt_a), 0);

    // 2. Single error while locked
    step(1'b0, 1'b1, 4'b0101, 1'b0, "t2");
    chk("t2_pulse", int'(pulse_a), 1);
    step(1'b0, 1'b1, 4'b1000, 1'b0, "t2");
    step(1'b0, 1'b1, 4'b0001, 1'b0, "t2");
    chk("t2_cnt", int'(cnt_a), 1);
    chk("t2_locked", int'(locked_a), 1);

    // 3. Loss of lock
    step(1'b0, 1'b1, 4'b0000, 1'b0, "t3");
    chk("t3_pulse0", int'(pulse_a), 1);
    step(1'b0, 1'b1, 4'b0011, 1'b0, "t3");
    chk("t3_pulse1", int'(pulse_a), 1);
    chk("t3_state", int'(st_a), 0);
    chk("t3_cnt", int'(cnt_a), 3);

    // 4. Gaps and wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, lock_seq[i], 1'b0, "t4lock");
    step(1'b0, 1'b1, 4'b1100, 1'b0, "t4");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, "t4idle");
    step(1'b0, 1'b1, 4'b1000, 1'b0, "t4");
    step(1'b0, 1'b1, 4'b0001, 1'b0, "t4");
    step(1'b0, 1'b1, 4'b0010, 1'b0, "t4");
    chk("t4_locked", int'(locked_a), 1);
    chk("t4_cnt", int'(cnt_a), 3);

    // 5. Saturation and clear
    step(1'b0, 1'b0, 4'd0, 1'b1, "t5clr");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, ref_next(m_exp), 1'b0, "t5miss");
      step(1'b0, 1'b1, m_exp, 1'b0, "t5hit");
    end
    chk("t5_sat2", int'(cnt_b), 3);
    chk("t5_cnt8", int'(cnt_a), 5);
    step(1'b0, 1'b1, ref_next(m_exp), 1'b1, "t5clrmiss");
    chk("t5_clr2", int'(cnt_b), 1);
    chk("t5_clr8", int'(cnt_a), 1);

    // 6. Reset mid-lock, then HUNT zero filter and seeding
    step(1'b1, 1'b0, 4'd0, 1'b0, "t6rst");
    chk("t6_rst_locked", int'(locked_a), 0);
    step(1'b0, 1'b1, 4'b0000, 1'b0, "t6zero");
    chk("t6_zero_hunt", int'(st_a), 0);
    step(1'b0, 1'b1, 4'b0100, 1'b0, "t6seed");
    chk("t6_verify", int'(st_a), 1);
    step(1'b0, 1'b1, 4'b1001, 1'b0, "t6");
    step(1'b0, 1'b1, 4'b0011, 1'b0, "t6");
    step(1'b0, 1'b1, 4'b0110, 1'b0, "t6");
    chk("t6_relock", int'(locked_a), 1);

    // Randomised stream: mostly in-sequence with corruptions, jumps, gaps, clears and resets
    pos = $urandom_range(0, 14);
    for (int n = 0; n < 3000; n++) begin
      logic c;
      c = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 99);
      if (r < 2) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), c, "rnd");
      else if (r < 14) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), c, "rnd");
      else if (r < 20) begin
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), c, "rnd");
        pos = (pos + 1) % 15;
      end else begin
        if (r < 23) pos = $urandom_range(0, 14);
        step(1'b0, 1'b1, 4'(seq[pos]), c, "rnd");
        pos = (pos + 1) % 15;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
